fill_arbiter: RTL and testbench

Shares the single inlet water line (cold and hot valves) between up to four washer FSMs in the laundry controller. Each washer raises a fill request; the arbiter grants the line to one washer at a time in round-robin order, drives the physical inlet valves on behalf of the granted washer, and enforces a maximum fill time with a timeout pulse. It sits between the per-washer FSMs and the valve drivers.

---
 rtl/fill_arbiter.sv | 139 +++++++++++++
 tb/tb_fill_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/fill_arbiter.sv
// Round-robin arbiter that lends the shared inlet water line to one washer at a time,
// drives the cold/hot valves for the granted washer and caps each grant at MAX_FILL cycles.
module fill_arbiter #(
  parameter int N_REQ    = 4,
  parameter int MAX_FILL = 20,
  parameter int GAP      = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_power,
  input  logic [N_REQ-1:0] i_req,
  input  logic [N_REQ-1:0] i_hot,
  input  logic [N_REQ-1:0] i_done,
  output logic [N_REQ-1:0] o_gnt,
  output logic             o_valve_in_cold,
  output logic             o_valve_in_hot,
  output logic [N_REQ-1:0] o_timeout,
  output logic             o_busy,
  output logic [7:0]       o_fill_timer
);

  localparam int PW = $clog2(N_REQ);

  typedef enum logic [1:0] {IDLE, FILL, RELEASE} state_t;

  state_t           r_state, w_nextState;
  logic [PW-1:0]    r_ptr, w_nextPtr;
  logic [PW-1:0]    r_win, w_nextWin;
  logic             r_hotSel, w_nextHotSel;
  logic [3:0]       r_gapCnt, w_nextGapCnt;
  logic [N_REQ-1:0] r_gnt, w_nextGnt;
  logic [N_REQ-1:0] r_timeout, w_nextTimeout;
  logic             r_valveCold, w_nextCold;
  logic             r_valveHot, w_nextHot;
  logic             r_busy;
  logic [7:0]       r_fillTimer, w_nextFillTimer;
  logic [PW-1:0]    w_pick;

  // Scan downward so the candidate closest to ptr+1 overwrites the others.
  function automatic logic [PW-1:0] pickWinner(input logic [PW-1:0] ptr,
                                               input logic [N_REQ-1:0] req);
    logic [PW-1:0] cand;
    pickWinner = ptr;
    for (int i = N_REQ; i >= 1; i--) begin
      cand = ptr + PW'(i);
      if (req[cand]) pickWinner = cand;
    end
  endfunction

  assign w_pick = pickWinner(r_ptr, i_req);

  always_comb begin
    w_nextState     = r_state;
    w_nextPtr       = r_ptr;
    w_nextWin       = r_win;
    w_nextHotSel    = r_hotSel;
    w_nextGapCnt    = r_gapCnt;
    w_nextGnt       = '0;
    w_nextTimeout   = '0;
    w_nextCold      = 1'b0;
    w_nextHot       = 1'b0;
    w_nextFillTimer = 8'd0;
    if (!i_power) begin
      w_nextState = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (|i_req) begin
            w_nextState     = FILL;
            w_nextGnt       = {{(N_REQ-1){1'b0}}, 1'b1} << w_pick;
            w_nextHotSel    = i_hot[w_pick];
            w_nextHot       = i_hot[w_pick];
            w_nextCold      = ~i_hot[w_pick];
            w_nextPtr       = w_pick;
            w_nextWin       = w_pick;
            w_nextFillTimer = 8'(MAX_FILL);
          end
        end
        FILL: begin
          if (i_done[r_win] || !i_req[r_win]) begin
            w_nextState  = RELEASE;
            w_nextGapCnt = 4'(GAP - 1);
          end else if (r_fillTimer == 8'd1) begin
            w_nextState   = RELEASE;
            w_nextGapCnt  = 4'(GAP - 1);
            w_nextTimeout = {{(N_REQ-1){1'b0}}, 1'b1} << r_win;
          end else begin
            w_nextGnt       = r_gnt;
            w_nextHot       = r_hotSel;
            w_nextCold      = ~r_hotSel;
            w_nextFillTimer = r_fillTimer - 8'd1;
          end
        end
        RELEASE: begin
          if (r_gapCnt == 4'd0) w_nextState = IDLE;
          else                  w_nextGapCnt = r_gapCnt - 4'd1;
        end
        default: w_nextState = IDLE;
      endcase
    end
  end

  // Pointer starts at the last washer so washer 0 has first priority after reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_ptr       <= PW'(N_REQ - 1);
      r_win       <= '0;
      r_hotSel    <= 1'b0;
      r_gapCnt    <= 4'd0;
      r_gnt       <= '0;
      r_timeout   <= '0;
      r_valveCold <= 1'b0;
      r_valveHot  <= 1'b0;
      r_busy      <= 1'b0;
      r_fillTimer <= 8'd0;
    end else begin
      r_state     <= w_nextState;
      r_ptr       <= w_nextPtr;
      r_win       <= w_nextWin;
      r_hotSel    <= w_nextHotSel;
      r_gapCnt    <= w_nextGapCnt;
      r_gnt       <= w_nextGnt;
      r_timeout   <= w_nextTimeout;
      r_valveCold <= w_nextCold;
      r_valveHot  <= w_nextHot;
      r_busy      <= (w_nextState != IDLE);
      r_fillTimer <= w_nextFillTimer;
    end
  end

  assign o_gnt           = r_gnt;
  assign o_valve_in_cold = r_valveCold;
  assign o_valve_in_hot  = r_valveHot;
  assign o_timeout       = r_timeout;
  assign o_busy          = r_busy;
  assign o_fill_timer    = r_fillTimer;

endmodule

// File: tb/tb_fill_arbiter.sv
// Scoreboard bench for fill_arbiter: each driven cycle pushes the output vector expected
// after the next rising edge; a monitor pops and compares it just after that edge.
module tb_fill_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       power = 1'b1;
  logic [3:0] req = 4'd0;
  logic [3:0] hot = 4'd0;
  logic [3:0] done = 4'd0;
  logic [3:0] gnt;
  logic       valveCold;
  logic       valveHot;
  logic [3:0] timeout;
  logic       busy;
  logic [7:0] fillTimer;

  int checks = 0;
  int errors = 0;

  logic [18:0] expQ[$];
  string       tagQ[$];

  fill_arbiter #(.N_REQ(4), .MAX_FILL(20), .GAP(2)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_power        (power),
    .i_req          (req),
    .i_hot          (hot),
    .i_done         (done),
    .o_gnt          (gnt),
    .o_valve_in_cold(valveCold),
    .o_valve_in_hot (valveHot),
    .o_timeout      (timeout),
    .o_busy         (busy),
    .o_fill_timer   (fillTimer)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", tag, observed, expected);
    end
  endtask

  // Drives one cycle of inputs and queues the outputs expected after the next edge.
  task automatic applyStimulus(input string tag, input logic r, input logic p,
                               input logic [3:0] rq, input logic [3:0] h,
                               input logic [3:0] d, input logic [18:0] e);
    @(negedge clk);
    rst   = r;
    power = p;
    req   = rq;
    hot   = h;
    done  = d;
    expQ.push_back(e);
    tagQ.push_back(tag);
  endtask

  function automatic logic [18:0] mkExp(input logic [3:0] g, input logic c, input logic hv,
                                        input logic [3:0] t, input logic b,
                                        input logic [7:0] tm);
    return {g, c, hv, t, b, tm};
  endfunction

  initial begin
    logic [18:0] e;
    string       tg;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() != 0) begin
        e  = expQ.pop_front();
        tg = tagQ.pop_front();
        checkOutput(tg, {13'd0, gnt, valveCold, valveHot, timeout, busy, fillTimer},
                    {13'd0, e});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired got running expected finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [18:0] idleE;
    logic [18:0] relE;
    logic [3:0]  hotv;
    logic [3:0]  oh;
    logic        hv;
    int          w;
    idleE = mkExp(4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 8'd0);
    relE  = mkExp(4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 8'd0);

    // Reset, single hot fill ended by done.
    applyStimulus("reset", 1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000, idleE);
    applyStimulus("t1_grant", 1'b0, 1'b1, 4'b0001, 4'b0001, 4'b0000,
                  mkExp(4'b0001, 1'b0, 1'b1, 4'd0, 1'b1, 8'd20));
    for (int k = 1; k <= 4; k++)
      applyStimulus("t1_hold", 1'b0, 1'b1, 4'b0001, 4'b0001, 4'b0000,
                    mkExp(4'b0001, 1'b0, 1'b1, 4'd0, 1'b1, 8'(20 - k)));
    applyStimulus("t1_done", 1'b0, 1'b1, 4'b0001, 4'b0001, 4'b0001, relE);
    applyStimulus("t1_gap", 1'b0, 1'b1, 4'b0000, 4'b0001, 4'b0000, relE);
    applyStimulus("t1_idle", 1'b0, 1'b1, 4'b0000, 4'b0001, 4'b0000, idleE);

    // Round robin with all four requesting, each ending 3 cycles into its grant.
    applyStimulus("t2_reset", 1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000, idleE);
    hotv = 4'b1010;
    for (int k = 0; k < 5; k++) begin
      w  = k % 4;
      oh = 4'b0001 << w;
      hv = hotv[w];
      applyStimulus("rr_grant", 1'b0, 1'b1, 4'b1111, hotv, 4'b0000,
                    mkExp(oh, ~hv, hv, 4'd0, 1'b1, 8'd20));
      applyStimulus("rr_hold", 1'b0, 1'b1, 4'b1111, hotv, 4'b0000,
                    mkExp(oh, ~hv, hv, 4'd0, 1'b1, 8'd19));
      applyStimulus("rr_hold", 1'b0, 1'b1, 4'b1111, hotv, 4'b0000,
                    mkExp(oh, ~hv, hv, 4'd0, 1'b1, 8'd18));
      applyStimulus("rr_done", 1'b0, 1'b1, 4'b1111, hotv, oh, relE);
      applyStimulus("rr_gap", 1'b0, 1'b1, 4'b1111, hotv, 4'b0000, relE);
      applyStimulus("rr_idle", 1'b0, 1'b1, 4'b1111, hotv, 4'b0000, idleE);
    end
    applyStimulus("t2_quiet", 1'b0, 1'b1, 4'b0000, hotv, 4'b0000, idleE);

    // Cold fill of washer 1 that runs into the timeout.
    applyStimulus("t3_grant", 1'b0, 1'b1, 4'b0010, 4'b0000, 4'b0000,
                  mkExp(4'b0010, 1'b1, 1'b0, 4'd0, 1'b1, 8'd20));
    for (int k = 1; k <= 19; k++)
      applyStimulus("t3_fill", 1'b0, 1'b1, 4'b0010, 4'b0000, 4'b0000,
                    mkExp(4'b0010, 1'b1, 1'b0, 4'd0, 1'b1, 8'(20 - k)));
    applyStimulus("t3_timeout", 1'b0, 1'b1, 4'b0010, 4'b0000, 4'b0000,
                  mkExp(4'b0000, 1'b0, 1'b0, 4'b0010, 1'b1, 8'd0));
    applyStimulus("t3_gap", 1'b0, 1'b1, 4'b0110, 4'b0000, 4'b0000, relE);
    applyStimulus("t3_idle", 1'b0, 1'b1, 4'b0110, 4'b0000, 4'b0000, idleE);
    applyStimulus("t3_next2", 1'b0, 1'b1, 4'b0110, 4'b0000, 4'b0000,
                  mkExp(4'b0100, 1'b1, 1'b0, 4'd0, 1'b1, 8'd20));
    applyStimulus("t3_done2", 1'b0, 1'b1, 4'b0110, 4'b0000, 4'b0100, relE);
    applyStimulus("t3_gap2", 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000, relE);
    applyStimulus("t3_idle2", 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000, idleE);

    // Hot toggles ignored during fill; dropping req releases without timeout.
    applyStimulus("t4_grant", 1'b0, 1'b1, 4'b0010, 4'b0000, 4'b0000,
                  mkExp(4'b0010, 1'b1, 1'b0, 4'd0, 1'b1, 8'd20));
    applyStimulus("t4_hot_on", 1'b0, 1'b1, 4'b0010, 4'b0010, 4'b0000,
                  mkExp(4'b0010, 1'b1, 1'b0, 4'd0, 1'b1, 8'd19));
    applyStimulus("t4_hot_off", 1'b0, 1'b1, 4'b0010, 4'b0000, 4'b0000,
                  mkExp(4'b0010, 1'b1, 1'b0, 4'd0, 1'b1, 8'd18));
    applyStimulus("t4_hot_on2", 1'b0, 1'b1, 4'b0010, 4'b0010, 4'b0000,
                  mkExp(4'b0010, 1'b1, 1'b0, 4'd0, 1'b1, 8'd17));
    applyStimulus("t4_req_drop", 1'b0, 1'b1, 4'b0000, 4'b0010, 4'b0000, relE);
    applyStimulus("t4_gap", 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000, relE);
    applyStimulus("t4_idle", 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000, idleE);

    // Power loss mid-fill, then recovery.
    applyStimulus("t5_grant", 1'b0, 1'b1, 4'b0001, 4'b0001, 4'b0000,
                  mkExp(4'b0001, 1'b0, 1'b1, 4'd0, 1'b1, 8'd20));
    applyStimulus("t5_hold", 1'b0, 1'b1, 4'b0001, 4'b0001, 4'b0000,
                  mkExp(4'b0001, 1'b0, 1'b1, 4'd0, 1'b1, 8'd19));
    applyStimulus("t5_power_off", 1'b0, 1'b0, 4'b0001, 4'b0001, 4'b0000, idleE);
    applyStimulus("t5_power_low", 1'b0, 1'b0, 4'b0001, 4'b0001, 4'b0000, idleE);
    applyStimulus("t5_power_on", 1'b0, 1'b1, 4'b0001, 4'b0001, 4'b0000,
                  mkExp(4'b0001, 1'b0, 1'b1, 4'd0, 1'b1, 8'd20));
    applyStimulus("t5_done", 1'b0, 1'b1, 4'b0001, 4'b0001, 4'b0001, relE);
    applyStimulus("t5_gap", 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000, relE);
    applyStimulus("t5_idle", 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000, idleE);

    // Reset mid-fill restores the pointer so washer 0 beats washer 3.
    applyStimulus("t6_grant", 1'b0, 1'b1, 4'b0010, 4'b0000, 4'b0000,
                  mkExp(4'b0010, 1'b1, 1'b0, 4'd0, 1'b1, 8'd20));
    applyStimulus("t6_hold", 1'b0, 1'b1, 4'b0010, 4'b0000, 4'b0000,
                  mkExp(4'b0010, 1'b1, 1'b0, 4'd0, 1'b1, 8'd19));
    applyStimulus("t6_reset", 1'b1, 1'b1, 4'b0010, 4'b0000, 4'b0000, idleE);
    applyStimulus("t6_ptr", 1'b0, 1'b1, 4'b1001, 4'b1000, 4'b0000,
                  mkExp(4'b0001, 1'b1, 1'b0, 4'd0, 1'b1, 8'd20));
    applyStimulus("t6_done", 1'b0, 1'b1, 4'b1001, 4'b1000, 4'b0001, relE);
    applyStimulus("t6_gap", 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000, relE);
    applyStimulus("t6_idle", 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000, idleE);

    @(posedge clk);
    #2;
    checkOutput("drain", 32'(expQ.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
